// File: rtl/bombe_pkg.sv
// Shared types and constants for the Bombe rotor stepper.
// Holds the default alphabet size, the 5-bit rotor position type,
// the stepper state encoding and a clamp helper used by rotor loads.
package bombe_pkg;

  // Positions per rotor when the parent does not override it (legal 2..32).
  localparam int ALPHABET_DEFAULT = 26;

  // Rotor position; 5 bits covers alphabets up to 32.
  typedef logic [4:0] pos_t;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } stepper_state_t;

  // Saturate a requested position to the last legal value of the alphabet.
  function automatic pos_t clamp_pos(input pos_t value, input pos_t max_pos);
    clamp_pos = (value > max_pos) ? max_pos : value;
  endfunction

endpackage

// File: rtl/rotor_digit.sv
// One rotor of the odometer: a mod-ALPHABET counter with carry out.
// Latency: position updates one cycle after inc/clear/load; carry is combinational.
// Priority is clear over load over inc; the value never reaches ALPHABET.
module rotor_digit
  import bombe_pkg::*;
#(
  parameter int ALPHABET = ALPHABET_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clear,
  input  logic load,
  input  pos_t load_val,
  output pos_t pos,
  output logic carry
);

  localparam pos_t MAX_POS = pos_t'(ALPHABET - 1);

  logic at_max;

  assign at_max = (pos == MAX_POS);

  // Carry to the next rotor when this one wraps on an increment.
  assign carry = inc && at_max;

  // Position register: clear, load (clamped) or wrap-around increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (clear) begin
      pos <= '0;
    end else if (load) begin
      pos <= clamp_pos(load_val, MAX_POS);
    end else if (inc) begin
      pos <= at_max ? '0 : pos + 5'd1;
    end
  end

endmodule

// File: rtl/bombe_rotor_stepper.sv
// Three-rotor odometer scanner driven by a slow tick, with halt/resume on candidate hits.
// Latency: one cycle from an accepted tick to the new positions, step_pulse and flags alongside.
// Optional BOMBE_STEPPER_LOAD_EN adds a preset load port usable outside RUN.
module bombe_rotor_stepper
  import bombe_pkg::*;
#(
  parameter int ALPHABET = ALPHABET_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop_hit,
  input  logic       resume,
`ifdef BOMBE_STEPPER_LOAD_EN
  input  logic       load,
  input  logic [4:0] load_l,
  input  logic [4:0] load_m,
  input  logic [4:0] load_r,
`endif
  output logic [4:0] rotor_l,
  output logic [4:0] rotor_m,
  output logic [4:0] rotor_r,
  output logic       step_pulse,
  output logic       running,
  output logic       halted,
  output logic       done
);

  stepper_state_t state;

  logic step;
  logic clear_all;
  logic load_en;
  pos_t load_val_l;
  pos_t load_val_m;
  pos_t load_val_r;
  logic carry_r;
  logic carry_m;
  logic carry_l;

  // A hit takes priority over a coincident tick, so a halted scan never moves.
  assign step      = (state == ST_RUN) && tick && !stop_hit;
  // Restarting after a completed scan begins again from the origin.
  assign clear_all = (state == ST_DONE) && start;

`ifdef BOMBE_STEPPER_LOAD_EN
  assign load_en    = load && (state != ST_RUN);
  assign load_val_l = load_l;
  assign load_val_m = load_m;
  assign load_val_r = load_r;
`else
  assign load_en    = 1'b0;
  assign load_val_l = '0;
  assign load_val_m = '0;
  assign load_val_r = '0;
`endif

  rotor_digit #(.ALPHABET(ALPHABET)) u_rotor_r (
    .clk      (CLOCK_50),
    .rst      (reset),
    .inc      (step),
    .clear    (clear_all),
    .load     (load_en),
    .load_val (load_val_r),
    .pos      (rotor_r),
    .carry    (carry_r)
  );

  rotor_digit #(.ALPHABET(ALPHABET)) u_rotor_m (
    .clk      (CLOCK_50),
    .rst      (reset),
    .inc      (carry_r),
    .clear    (clear_all),
    .load     (load_en),
    .load_val (load_val_m),
    .pos      (rotor_m),
    .carry    (carry_m)
  );

  rotor_digit #(.ALPHABET(ALPHABET)) u_rotor_l (
    .clk      (CLOCK_50),
    .rst      (reset),
    .inc      (carry_m),
    .clear    (clear_all),
    .load     (load_en),
    .load_val (load_val_l),
    .pos      (rotor_l),
    .carry    (carry_l)
  );

  // Scan controller with registered one-hot flags and step pulse.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      step_pulse <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_pulse <= step;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_hit) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (tick && carry_l) begin
            // Left rotor carry means every rotor just wrapped: scan exhausted.
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state   <= ST_RUN;
            halted  <= 1'b0;
            running <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state   <= ST_RUN;
            done    <= 1'b0;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Directed self-checking bench for bombe_rotor_stepper with the default 26-position alphabet.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Covers reset, odometer carries, terminal wrap, halt/resume, async reset and optional load.
module tb_bombe_rotor_stepper;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop_hit;
  logic       resume;
  logic [4:0] rotor_l;
  logic [4:0] rotor_m;
  logic [4:0] rotor_r;
  logic       step_pulse;
  logic       running;
  logic       halted;
  logic       done;
`ifdef BOMBE_STEPPER_LOAD_EN
  logic       load;
  logic [4:0] load_l;
  logic [4:0] load_m;
  logic [4:0] load_r;
`endif

  int errors;
  int checks;

  bombe_rotor_stepper #(.ALPHABET(26)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .stop_hit   (stop_hit),
    .resume     (resume),
`ifdef BOMBE_STEPPER_LOAD_EN
    .load       (load),
    .load_l     (load_l),
    .load_m     (load_m),
    .load_r     (load_r),
`endif
    .rotor_l    (rotor_l),
    .rotor_m    (rotor_m),
    .rotor_r    (rotor_r),
    .step_pulse (step_pulse),
    .running    (running),
    .halted     (halted),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, leaving time at edge + 1 ns.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    cycles(n);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== 15'd0) begin
      errors++;
      $display("FAIL reset_pos got (%0d,%0d,%0d) want (0,0,0)", rotor_l, rotor_m, rotor_r);
    end
    checks++;
    if ({running, halted, done, step_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got r/h/d/p=%b want 0000", {running, halted, done, step_pulse});
    end
    cycles(1);
    reset = 1'b0;
    // tick, stop_hit and resume in IDLE must do nothing
    tick = 1'b1; stop_hit = 1'b1; resume = 1'b1;
    cycles(2);
    tick = 1'b0; stop_hit = 1'b0; resume = 1'b0;
    checks++;
    if ({rotor_l, rotor_m, rotor_r, running, halted, done, step_pulse} !== 19'd0) begin
      errors++;
      $display("FAIL idle_ignore got (%0d,%0d,%0d) r/h/d/p=%b want (0,0,0) 0000",
               rotor_l, rotor_m, rotor_r, {running, halted, done, step_pulse});
    end
  endtask

  task automatic test_basic_step();
    int pulses;
    apply_reset();
    do_start();
    checks++;
    if ({running, halted, done, rotor_l, rotor_m, rotor_r} !== {3'b100, 15'd0}) begin
      errors++;
      $display("FAIL start_run got r/h/d=%b (%0d,%0d,%0d) want 100 (0,0,0)",
               {running, halted, done}, rotor_l, rotor_m, rotor_r);
    end
    pulses = 0;
    tick = 1'b1;
    repeat (3) begin
      cycles(1);
      if (step_pulse) pulses++;
    end
    tick = 1'b0;
    cycles(1);
    if (step_pulse) pulses++;
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== {5'd0, 5'd0, 5'd3}) begin
      errors++;
      $display("FAIL three_ticks_pos got (%0d,%0d,%0d) want (0,0,3)", rotor_l, rotor_m, rotor_r);
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL three_ticks_pulses got %0d want 3", pulses);
    end
    // start while running is ignored
    do_start();
    checks++;
    if ({running, halted, done, rotor_l, rotor_m, rotor_r} !== {3'b100, 5'd0, 5'd0, 5'd3}) begin
      errors++;
      $display("FAIL start_in_run got r/h/d=%b (%0d,%0d,%0d) want 100 (0,0,3)",
               {running, halted, done}, rotor_l, rotor_m, rotor_r);
    end
  endtask

  task automatic test_carry();
    apply_reset();
    do_start();
    run_ticks(25);
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== {5'd0, 5'd0, 5'd25}) begin
      errors++;
      $display("FAIL reach_0_0_25 got (%0d,%0d,%0d) want (0,0,25)", rotor_l, rotor_m, rotor_r);
    end
    run_ticks(1);
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== {5'd0, 5'd1, 5'd0}) begin
      errors++;
      $display("FAIL carry_r got (%0d,%0d,%0d) want (0,1,0)", rotor_l, rotor_m, rotor_r);
    end
    // (0,1,0) is index 26; (0,25,25) is index 675
    run_ticks(649);
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== {5'd0, 5'd25, 5'd25}) begin
      errors++;
      $display("FAIL reach_0_25_25 got (%0d,%0d,%0d) want (0,25,25)", rotor_l, rotor_m, rotor_r);
    end
    run_ticks(1);
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== {5'd1, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL carry_m got (%0d,%0d,%0d) want (1,0,0)", rotor_l, rotor_m, rotor_r);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_start();
    run_ticks(17575);
    checks++;
    if ({running, halted, done, rotor_l, rotor_m, rotor_r} !== {3'b100, 5'd25, 5'd25, 5'd25}) begin
      errors++;
      $display("FAIL reach_max got r/h/d=%b (%0d,%0d,%0d) want 100 (25,25,25)",
               {running, halted, done}, rotor_l, rotor_m, rotor_r);
    end
    run_ticks(1);
    checks++;
    if ({running, halted, done, step_pulse, rotor_l, rotor_m, rotor_r} !== {4'b0011, 15'd0}) begin
      errors++;
      $display("FAIL terminal_wrap got r/h/d/p=%b (%0d,%0d,%0d) want 0011 (0,0,0)",
               {running, halted, done, step_pulse}, rotor_l, rotor_m, rotor_r);
    end
    // ticks in DONE do nothing
    run_ticks(2);
    checks++;
    if ({running, halted, done, step_pulse, rotor_l, rotor_m, rotor_r} !== {4'b0010, 15'd0}) begin
      errors++;
      $display("FAIL done_ignore_tick got r/h/d/p=%b (%0d,%0d,%0d) want 0010 (0,0,0)",
               {running, halted, done, step_pulse}, rotor_l, rotor_m, rotor_r);
    end
    do_start();
    checks++;
    if ({running, halted, done, rotor_l, rotor_m, rotor_r} !== {3'b100, 15'd0}) begin
      errors++;
      $display("FAIL restart_from_done got r/h/d=%b (%0d,%0d,%0d) want 100 (0,0,0)",
               {running, halted, done}, rotor_l, rotor_m, rotor_r);
    end
    run_ticks(1);
    checks++;
    if ({rotor_l, rotor_m, rotor_r} !== {5'd0, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL step_after_restart got (%0d,%0d,%0d) want (0,0,1)", rotor_l, rotor_m, rotor_r);
    end
  endtask

  task automatic test_halt_resume();
    apply_reset();
    do_start();
    // (2,5,7) is index 2*676 + 5*26 + 7 = 1489
    run_ticks(1489);
    tick = 1'b1; stop_hit = 1'b1;
    cycles(1);
    tick = 1'b0; stop_hit = 1'b0;
    checks++;
    if ({running, halted, done, step_pulse, rotor_l, rotor_m, rotor_r} !== {4'b0100, 5'd2, 5'd5, 5'd7}) begin
      errors++;
      $display("FAIL halt_wins got r/h/d/p=%b (%0d,%0d,%0d) want 0100 (2,5,7)",
               {running, halted, done, step_pulse}, rotor_l, rotor_m, rotor_r);
    end
    // tick, start and stop_hit while halted have no effect
    tick = 1'b1; start = 1'b1; stop_hit = 1'b1;
    cycles(2);
    tick = 1'b0; start = 1'b0; stop_hit = 1'b0;
    checks++;
    if ({running, halted, done, rotor_l, rotor_m, rotor_r} !== {3'b010, 5'd2, 5'd5, 5'd7}) begin
      errors++;
      $display("FAIL halt_hold got r/h/d=%b (%0d,%0d,%0d) want 010 (2,5,7)",
               {running, halted, done}, rotor_l, rotor_m, rotor_r);
    end
    resume = 1'b1; tick = 1'b1;
    cycles(1);
    resume = 1'b0; tick = 1'b0;
    checks++;
    if ({running, halted, done, step_pulse, rotor_l, rotor_m, rotor_r} !== {4'b1000, 5'd2, 5'd5, 5'd7}) begin
      errors++;
      $display("FAIL resume_no_step got r/h/d/p=%b (%0d,%0d,%0d) want 1000 (2,5,7)",
               {running, halted, done, step_pulse}, rotor_l, rotor_m, rotor_r);
    end
    run_ticks(1);
    checks++;
    if ({step_pulse, rotor_l, rotor_m, rotor_r} !== {1'b1, 5'd2, 5'd5, 5'd8}) begin
      errors++;
      $display("FAIL resume_first_step got p=%b (%0d,%0d,%0d) want 1 (2,5,8)",
               step_pulse, rotor_l, rotor_m, rotor_r);
    end
    cycles(1);
    checks++;
    if (step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_one_cycle got %b want 0", step_pulse);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_start();
    // (4,4,4) is index 4*676 + 4*26 + 4 = 2812
    run_ticks(2812);
    checks++;
    if ({step_pulse, rotor_l, rotor_m, rotor_r} !== {1'b1, 5'd4, 5'd4, 5'd4}) begin
      errors++;
      $display("FAIL reach_4_4_4 got p=%b (%0d,%0d,%0d) want 1 (4,4,4)",
               step_pulse, rotor_l, rotor_m, rotor_r);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({running, halted, done, step_pulse, rotor_l, rotor_m, rotor_r} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got r/h/d/p=%b (%0d,%0d,%0d) want 0000 (0,0,0)",
               {running, halted, done, step_pulse}, rotor_l, rotor_m, rotor_r);
    end
    cycles(1);
    reset = 1'b0;
    do_start();
    checks++;
    if ({running, halted, done} !== 3'b100) begin
      errors++;
      $display("FAIL start_after_reset got r/h/d=%b want 100", {running, halted, done});
    end
  endtask

`ifdef BOMBE_STEPPER_LOAD_EN
  task automatic test_load();
    apply_reset();
    load = 1'b1; load_l = 5'd30; load_m = 5'd3; load_r = 5'd1;
    cycles(1);
    load = 1'b0;
    checks++;
    if ({running, halted, done, rotor_l, rotor_m, rotor_r} !== {3'b000, 5'd25, 5'd3, 5'd1}) begin
      errors++;
      $display("FAIL load_idle got r/h/d=%b (%0d,%0d,%0d) want 000 (25,3,1)",
               {running, halted, done}, rotor_l, rotor_m, rotor_r);
    end
    do_start();
    load = 1'b1; load_l = 5'd0; load_m = 5'd0; load_r = 5'd9;
    cycles(1);
    load = 1'b0;
    checks++;
    if ({running, rotor_l, rotor_m, rotor_r} !== {1'b1, 5'd25, 5'd3, 5'd1}) begin
      errors++;
      $display("FAIL load_in_run got run=%b (%0d,%0d,%0d) want 1 (25,3,1)",
               running, rotor_l, rotor_m, rotor_r);
    end
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    stop_hit = 1'b0;
    resume   = 1'b0;
`ifdef BOMBE_STEPPER_LOAD_EN
    load     = 1'b0;
    load_l   = '0;
    load_m   = '0;
    load_r   = '0;
`endif
    #1;
    test_reset();
    test_basic_step();
    test_carry();
    test_wrap();
    test_halt_resume();
    test_async_reset();
`ifdef BOMBE_STEPPER_LOAD_EN
    test_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
